modred_arbiter: RTL

Round-robin arbiter that shares one word-level Montgomery modular-reduction pipeline between N_REQ requesters (NTT butterfly lanes, key-switch accumulators). It issues at most one operand per cycle into the fixed-latency, non-stallable reduction datapath. A tag shift register tracks the requester ID of every operand in flight. Results land in a result FIFO sized so the datapath never needs to stall, and leave through a single valid/ready response port tagged with the requester ID.

---
 rtl/modred_arbiter_pkg.sv | 28 ++
 rtl/modred_rsp_fifo.sv | 74 +++++++
 rtl/modred_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/modred_arbiter_pkg.sv
// Shared definitions for the modular-reduction arbiter: parameter defaults,
// datapath latency per word stage, and the in-flight tag record.
package modred_arbiter_pkg;

  localparam int unsigned DEF_N_REQ  = 4;
  localparam int unsigned DEF_DIN_W  = 64;
  localparam int unsigned DEF_DOUT_W = 32;

  // Each Montgomery word stage costs two pipeline cycles.
  localparam int unsigned CYCLES_PER_WORD_STAGE = 2;
  localparam int unsigned DEF_WORD_STAGES       = 3;

  function automatic int unsigned lat_for_stages(input int unsigned stages);
    return CYCLES_PER_WORD_STAGE * stages;
  endfunction

  localparam int unsigned DEF_LAT   = lat_for_stages(DEF_WORD_STAGES);
  localparam int unsigned DEF_DEPTH = DEF_LAT + 2;

  // Tag id is sized for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W = 3;

  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/modred_rsp_fifo.sv
// First-word fall-through result FIFO of {data, id} entries.
// Ports: clk/reset (async active-low); push + push_data/push_id write the
// tail; pop removes the head when rd_valid; rd_valid/rd_data/rd_id present
// the head; count is the registered occupancy.
module modred_rsp_fifo
  import modred_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DOUT_W,
  parameter int unsigned ID_W   = 2,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ID_W-1:0]   push_id,
  input  logic              pop,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ID_W-1:0]   rd_id,
  output logic [CNT_W-1:0]  count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ID_W-1:0]   id_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;
  logic [CNT_W-1:0]  count_nxt;

  // Pointer increment with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy bookkeeping; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    do_pop    = pop && rd_valid;
    count_nxt = count + CNT_W'(push) - CNT_W'(do_pop);
  end

  // Storage, pointers and registered valid flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        id_mem[i]   <= '0;
      end
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        id_mem[wr_ptr]   <= push_id;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count    <= count_nxt;
      rd_valid <= (count_nxt != '0);
    end
  end

  // Head of queue is always visible (fall-through).
  assign rd_data = data_mem[rd_ptr];
  assign rd_id   = id_mem[rd_ptr];

endmodule

// File: rtl/modred_arbiter.sv
// Round-robin arbiter feeding one fixed-latency, non-stallable Montgomery
// reduction datapath, with a tag pipe tracking requester ids in flight and a
// result FIFO returning tagged responses.
// Ports: clk, reset (async active-low); req_valid/req_ready/req_data per
// requester; pause blocks new grants; red_t1 drives the datapath operand and
// red_c returns its result LAT cycles later; rsp_valid/rsp_ready/rsp_data/
// rsp_id form the response port; busy flags outstanding work.
module modred_arbiter
  import modred_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned DIN_W  = DEF_DIN_W,
  parameter int unsigned DOUT_W = DEF_DOUT_W,
  parameter int unsigned LAT    = DEF_LAT,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*DIN_W-1:0] req_data,
  input  logic                   pause,
  output logic [DIN_W-1:0]       red_t1,
  input  logic [DOUT_W-1:0]      red_c,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DOUT_W-1:0]      rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic                   busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned INF_W = $clog2(LAT + 2);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  next_ptr;
  logic             found;
  int unsigned      idx;
  logic             credit_ok;
  logic             grant;
  logic [DIN_W-1:0] pick_data;

  tag_t             tag_pipe [LAT+1];
  logic             push;
  logic [ID_W-1:0]  push_id;
  logic             pop;
  logic [INF_W-1:0] inflight;
  logic [INF_W-1:0] inflight_nxt;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] fifo_count_nxt;

  // Round-robin pick: first asserted request at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[ID_W-1:0];
      end
    end
  end

  // Grant decision. Credit uses registered FIFO occupancy, so a pop only
  // frees a slot on the following cycle and a push can never overflow.
  always_comb begin
    credit_ok = (32'(fifo_count) + 32'(inflight)) < DEPTH;
    grant     = reset && found && !pause && credit_ok;
    req_ready = grant ? (N_REQ'(1) << pick) : '0;
    pick_data = req_data[32'(pick)*DIN_W +: DIN_W];
    next_ptr  = (32'(pick) == N_REQ - 1) ? '0 : pick + ID_W'(1);
  end

  // Tag pipe exit marks the cycle red_c carries a live result.
  always_comb begin
    push           = tag_pipe[LAT].v;
    push_id        = ID_W'(tag_pipe[LAT].id);
    pop            = rsp_valid && rsp_ready;
    inflight_nxt   = inflight + INF_W'(grant) - INF_W'(push);
    fifo_count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
  end

  // Issue register, pointer, tag pipe, in-flight counter and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      red_t1   <= '0;
      inflight <= '0;
      busy     <= 1'b0;
      for (int unsigned i = 0; i <= LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      if (grant) begin
        rr_ptr <= next_ptr;
        red_t1 <= pick_data;
      end
      tag_pipe[0] <= tag_t'{v: grant, id: TAG_ID_W'(pick)};
      for (int unsigned i = 1; i <= LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
      inflight <= inflight_nxt;
      busy     <= (inflight_nxt != '0) || (fifo_count_nxt != '0);
    end
  end

  modred_rsp_fifo #(
    .DATA_W (DOUT_W),
    .ID_W   (ID_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (red_c),
    .push_id   (push_id),
    .pop       (pop),
    .rd_valid  (rsp_valid),
    .rd_data   (rsp_data),
    .rd_id     (rsp_id),
    .count     (fifo_count)
  );

endmodule
